// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_FULL,
    WB_STALLED
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic                  byte_op;
  } wb_slot_t;

  // Value a reader would see after the register file applies the byte zero-extension.
  function automatic logic [DATA_W-1:0] wb_visible_value(input wb_slot_t s);
    return s.byte_op ? {{(DATA_W-8){1'b0}}, s.data[7:0]} : s.data;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// Rotating-priority encoder: first valid requester at or above the pointer (wrapping) wins.
module rr_grant #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (i_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        w_idx = PW'((32'(i_ptr) + i) % N);
        if (!w_found && i_valid[w_idx]) begin
          o_grant[w_idx] = 1'b1;
          w_found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter feeding the register file's single write port through a one-entry slot.
// Optional macro WB_FWD_EN adds a two-port bypass from the pending write to the read paths.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_byte,
  input  logic                          wb_stall,
  output logic                          regWrite,
  output logic [REG_ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]             write_data,
  output logic                          byteOperations,
  output logic [CNT_W-1:0]              conflict_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]         fwd_reg1,
  input  logic [REG_ADDR_W-1:0]         fwd_reg2,
  input  logic [DATA_W-1:0]             rf_data1,
  input  logic [DATA_W-1:0]             rf_data2,
  output logic [DATA_W-1:0]             fwd_data1,
  output logic [DATA_W-1:0]             fwd_data2
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_state_e        r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  wb_slot_t         r_slot;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  wb_slot_t           w_sel;
  logic [PW-1:0]      w_win;
  logic               w_can_accept;
  logic               w_xfer;
  logic               w_load;
  logic               w_conflict;

  assign w_can_accept = rst_n &&
                        ((r_state == WB_EMPTY) || (r_state == WB_FULL && !wb_stall));

  rr_grant #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_grant (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_can_accept),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel = '0;
    w_win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.rd      = req_reg[REG_ADDR_W*i +: REG_ADDR_W];
        w_sel.data    = req_data[DATA_W*i +: DATA_W];
        w_sel.byte_op = req_byte[i];
        w_win         = PW'(i);
      end
    end
  end

  assign w_xfer     = |(req_valid & w_grant);
  // Writes to register 0 are consumed for fairness but never reach the slot.
  assign w_load     = w_xfer && (w_sel.rd != '0);
  assign w_conflict = ($countones(req_valid) > 1);

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_xfer) begin
      w_ptr_nxt = (w_win == PW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WB_EMPTY:   if (w_load) w_state_nxt = WB_FULL;
      WB_FULL: begin
        if (wb_stall)    w_state_nxt = WB_STALLED;
        else if (w_load) w_state_nxt = WB_FULL;
        else             w_state_nxt = WB_EMPTY;
      end
      // The held write retires in the cycle the stall drops; grants resume after.
      WB_STALLED: if (!wb_stall) w_state_nxt = WB_EMPTY;
      default:    w_state_nxt = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WB_EMPTY;
      r_ptr   <= '0;
      r_slot  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_load) r_slot <= w_sel;
      if (w_conflict && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign regWrite       = (r_state != WB_EMPTY);
  assign write_reg      = r_slot.rd;
  assign write_data     = r_slot.data;
  assign byteOperations = r_slot.byte_op;
  assign conflict_cnt   = r_cnt;

`ifdef WB_FWD_EN
  assign fwd_data1 = (regWrite && write_reg == fwd_reg1 && fwd_reg1 != '0) ?
                     wb_visible_value(r_slot) : rf_data1;
  assign fwd_data2 = (regWrite && write_reg == fwd_reg2 && fwd_reg2 != '0) ?
                     wb_visible_value(r_slot) : rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter; also exercises WB_FWD_EN when defined.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_reg;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_byte;
  logic            wb_stall;
  logic            regWrite;
  logic [4:0]      write_reg;
  logic [31:0]     write_data;
  logic            byteOperations;
  logic [CW-1:0]   conflict_cnt;
`ifdef WB_FWD_EN
  logic [4:0]      fwd_reg1, fwd_reg2;
  logic [31:0]     rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_reg        (req_reg),
    .req_data       (req_data),
    .req_byte       (req_byte),
    .wb_stall       (wb_stall),
    .regWrite       (regWrite),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .byteOperations (byteOperations),
    .conflict_cnt   (conflict_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_reg1       (fwd_reg1),
    .fwd_reg2       (fwd_reg2),
    .rf_data1       (rf_data1),
    .rf_data2       (rf_data2),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Requester-side state: each source holds valid/payload until it sees its transfer.
  logic [N-1:0] d_valid;
  logic [4:0]   d_reg  [N];
  logic [31:0]  d_data [N];
  logic         d_byte [N];

  // Reference model state: who holds the port, whether it is frozen, and fairness pointer.
  int           m_ptr;
  bit           m_busy, m_stalled;
  int           m_cnt;
  int           m_win;
  logic [N-1:0] m_exp_ready;
  logic [N-1:0] m_xfer;
  wb_slot_t     exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; m_busy = 0; m_stalled = 0; m_cnt = 0; m_xfer = '0;
      exp_q.delete();
    end else begin
      m_win = -1;
      m_exp_ready = '0;
      if (!m_busy || (!m_stalled && !wb_stall)) begin
        for (int off = 0; off < N; off++) begin
          if (m_win < 0 && req_valid[(m_ptr + off) % N]) m_win = (m_ptr + off) % N;
        end
      end
      if (m_win >= 0) m_exp_ready[m_win] = 1'b1;
      chk("req_ready", req_ready, m_exp_ready);
      chk("regWrite", regWrite, m_busy);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      m_xfer = m_exp_ready;
      if ($countones(req_valid) > 1 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_win >= 0) begin
        m_ptr = (m_win + 1) % N;
        m_stalled = 0;
        if (d_reg[m_win] != 5'd0) begin
          exp_q.push_back('{rd: d_reg[m_win], data: d_data[m_win], byte_op: d_byte[m_win]});
          m_busy = 1;
        end else begin
          m_busy = 0;
        end
      end else if (m_busy && m_stalled) begin
        if (!wb_stall) begin m_busy = 0; m_stalled = 0; end
      end else if (m_busy) begin
        if (wb_stall) m_stalled = 1;
        else m_busy = 0;
      end
    end
  end

  // Monitor: a write pulse is new unless the previous cycle showed a write under stall.
  bit       mon_prev_rw, mon_prev_stall;
  wb_slot_t mon_cur;
`ifdef WB_FWD_EN
  logic [31:0] mon_vis;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_rw = 0; mon_prev_stall = 0; mon_cur = '0;
    end else begin
      if (regWrite) begin
        if (!(mon_prev_rw && mon_prev_stall)) begin
          chk("wb_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) mon_cur = exp_q.pop_front();
        end
        chk("write_reg", write_reg, mon_cur.rd);
        chk("write_data", write_data, mon_cur.data);
        chk("byteOperations", byteOperations, mon_cur.byte_op);
      end
`ifdef WB_FWD_EN
      mon_vis = mon_cur.byte_op ? {24'h0, mon_cur.data[7:0]} : mon_cur.data;
      chk("fwd_data1", fwd_data1,
          (regWrite && fwd_reg1 != 0 && fwd_reg1 == mon_cur.rd) ? mon_vis : rf_data1);
      chk("fwd_data2", fwd_data2,
          (regWrite && fwd_reg2 != 0 && fwd_reg2 == mon_cur.rd) ? mon_vis : rf_data2);
`endif
      mon_prev_rw    = regWrite;
      mon_prev_stall = wb_stall;
    end
  end

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_reg[5*i +: 5]   = d_reg[i];
      req_data[32*i +: 32] = d_data[i];
      req_byte[i]          = d_byte[i];
    end
    req_valid = d_valid;
  endtask

  task automatic drive(input int p_valid, input int p_stall, input int p_zero);
    for (int i = 0; i < N; i++) begin
      if (!d_valid[i] || m_xfer[i]) begin
        d_valid[i] = ($urandom_range(0, 99) < p_valid);
        d_reg[i]   = ($urandom_range(0, 99) < p_zero) ? 5'd0 : 5'($urandom_range(1, 31));
        d_data[i]  = $urandom;
        d_byte[i]  = 1'($urandom_range(0, 1));
      end
    end
    wb_stall = ($urandom_range(0, 99) < p_stall);
`ifdef WB_FWD_EN
    fwd_reg1 = $urandom_range(0, 1) ? write_reg : 5'($urandom_range(0, 31));
    fwd_reg2 = $urandom_range(0, 1) ? write_reg : 5'($urandom_range(0, 31));
    rf_data1 = $urandom;
    rf_data2 = $urandom;
`endif
    pack();
  endtask

  task automatic run_phase(input int cycles, input int p_valid, input int p_stall, input int p_zero);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      drive(p_valid, p_stall, p_zero);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    wb_stall = 1'b0;
    d_valid  = '0;
    for (int i = 0; i < N; i++) begin
      d_reg[i] = '0; d_data[i] = '0; d_byte[i] = 1'b0;
    end
`ifdef WB_FWD_EN
    fwd_reg1 = '0; fwd_reg2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif
    pack();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    chk("rst_req_ready", req_ready, 0);
    #2 rst_n = 1'b1;

    // All sources busy from reset: strict rotation, back-to-back writes, counter saturates.
    run_phase(40, 100, 0, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_regWrite", regWrite, 0);
    chk("async_rst_conflict_cnt", conflict_cnt, 0);
    d_valid  = '0;
    wb_stall = 1'b0;
    pack();
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_phase(300, 50, 25, 15);
    run_phase(300, 30, 10, 40);
    run_phase(200, 80, 50, 5);

    run_phase(10, 0, 0, 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Round-robin arbiter and sequencer for the single write port of the 32x32 register file.
- NUM_REQ writeback sources compete for the port: ALU result, load data, and the multi-cycle mult/div unit.
- Grants one source per cycle and registers the winning write into a one-entry output slot.
- Drives the register file's regWrite, write_reg, write_data and byteOperations inputs as a single-cycle write pulse.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_reg  input  NUM_REQ*5  destination register; requester i owns bits [5i+4:5i].
- req_data  input  NUM_REQ*32  write data; requester i owns bits [32i+31:32i].
- req_byte  input  NUM_REQ  byte-operation flag per requester.
- wb_stall  input  1  register-file side hold; freezes the output slot.
- regWrite  output  1  write enable to the register file.
- write_reg  output  5  write address.
- write_data  output  32  write data.
- byteOperations  output  1  byte flag; the register file performs the zero-extension.
- conflict_cnt  output  CNT_W  count of cycles with more than one req_valid asserted.

Behaviour:
- Reset (async, rst_n=0):
  - regWrite=0, write_reg=0, write_data=0, byteOperations=0, conflict_cnt=0.
  - RR pointer=0, state=EMPTY, req_ready=0.
- States:
  - EMPTY: slot free, regWrite=0.
  - FULL: slot holds a write, regWrite=1.
  - STALLED: slot holds a write, wb_stall=1, regWrite stays 1.
- can_accept = (state==EMPTY) || (state==FULL && !wb_stall).
- Grant:
  - When can_accept, scan from the RR pointer upward (wrapping) for the first req_valid.
  - The winner gets req_ready=1; all other ready bits are 0.
  - Transfer occurs on req_valid & req_ready in the same cycle.
- Requesters hold valid and payload stable until ready; valid must not drop before transfer.
- On transfer from requester k:
  - Pointer becomes (k+1) mod NUM_REQ.
  - The slot loads req_reg/req_data/req_byte of k on the next edge.
- Latency: a request accepted in cycle N appears with regWrite=1 in cycle N+1 for exactly one cycle, unless stalled.
- Register 0:
  - The request is accepted and the pointer advances.
  - The slot is not loaded; next state is EMPTY; no write pulse is issued.
- Transitions:
  - EMPTY -> FULL on a transfer with nonzero reg.
  - FULL -> FULL on a transfer with !wb_stall; back-to-back writes, one per cycle.
  - FULL -> EMPTY with no transfer and !wb_stall.
  - FULL -> STALLED when wb_stall=1.
  - STALLED -> EMPTY when wb_stall drops; no grant is issued in the cycle wb_stall is high.
- wb_stall while EMPTY: no effect, grants proceed.
- conflict_cnt increments by 1 each cycle where popcount(req_valid)>1; saturates at all-ones and never wraps.
- The slot and regWrite outputs are flopped; no combinational path from req_* to the register-file outputs.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, adds ports:
  - fwd_reg1, fwd_reg2: inputs, 5 bits.
  - rf_data1, rf_data2: inputs, 32 bits.
  - fwd_data1, fwd_data2: outputs, 32 bits.
- With WB_FWD_EN, fwd_dataX is combinational:
  - If regWrite && write_reg==fwd_regX && fwd_regX!=0, fwd_dataX = byteOperations ? {24'b0, write_data[7:0]} : write_data.
  - Otherwise fwd_dataX = rf_dataX.
- Without WB_FWD_EN, the ports are absent and readers use the register file directly.

Decomposition:
- Package regfile_wb_pkg holds:
  - REG_ADDR_W=5, DATA_W=32.
  - State enum {WB_EMPTY, WB_FULL, WB_STALLED}.
  - Slot struct {reg, data, byte}.
- One natural sub-module, rr_grant: combinational rotate-priority-encoder taking valid, pointer and enable, producing a one-hot grant.

Test Plan:
- Single request: req_valid=001, reg=5, data=0xDEADBEEF, byte=0 -> ready[0]=1 in the same cycle; next cycle regWrite=1, write_reg=5, write_data=0xDEADBEEF; the cycle after, regWrite=0.
- Round-robin with all three valid continuously from reset -> grant order 0,1,2,0,1,2; regWrite stays high each cycle; conflict_cnt increments by 1 per cycle.
- Stall: slot FULL with reg=7, wb_stall=1 for 3 cycles with req_valid=010 -> outputs hold reg 7, req_ready=000; after stall release, req 1 is granted the next cycle.
- Register 0: req_valid=100, reg=0 -> ready[2]=1, regWrite stays 0, pointer moves to 0.
- Byte write: byte=1, data=0x123456AB -> byteOperations=1 with write_data=0x123456AB; with WB_FWD_EN and fwd_reg1 matching, fwd_data1=0x000000AB.
- Reset mid-operation: assert rst_n=0 while FULL -> regWrite=0 immediately (async), conflict_cnt=0, pointer=0.
